// File: rtl/regfile_writeback_if.sv
//------------------------------------------------------------------------------
// regfile_writeback_if : ALU/load result, load-issue, decode and writeback bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_load;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_din;
  logic        waw_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_load, issue_rd, rs1_addr, rs2_addr,
    input  mem_ready, hazard, rf_we, rf_rd_addr, rf_rd_din, waw_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_load, issue_rd, rs1_addr, rs2_addr,
    output mem_ready, hazard, rf_we, rf_rd_addr, rf_rd_din, waw_err
  );
endinterface

`default_nettype wire

// File: rtl/regfile_writeback.sv
//------------------------------------------------------------------------------
// regfile_writeback : merges ALU and buffered load results into one RF write
//                     port and tracks pending-load (busy) registers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rstn,
  regfile_writeback_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      busy_q, busy_d;
  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_din_q, rf_din_d;
  logic             waw_q, waw_d;
  logic             mem_ready_w, push, pop;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;

  // Ready depends only on occupancy, never on mem_valid.
  assign mem_ready_w = (count_q < DEPTH_C);
  assign head_rd     = fifo_rd_q[rptr_q];
  assign head_data   = fifo_data_q[rptr_q];

  always_comb begin
    push      = bus.mem_valid & mem_ready_w;
    pop       = ~bus.alu_valid & (count_q != '0);
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_din_d  = rf_din_q;
    busy_d    = busy_q;
    waw_d     = waw_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    if (bus.alu_valid) begin
      rf_we_d   = (bus.alu_rd != 5'd0);
      rf_addr_d = bus.alu_rd;
      rf_din_d  = bus.alu_data;
      if (bus.alu_rd != 5'd0 && busy_q[bus.alu_rd]) waw_d = 1'b1;
    end else if (pop) begin
      rf_we_d   = (head_rd != 5'd0);
      rf_addr_d = head_rd;
      rf_din_d  = head_data;
    end

    // Clear first so a same-edge issue to the same register wins.
    if (pop) busy_d[head_rd] = 1'b0;
    if (bus.issue_load && bus.issue_rd != 5'd0) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_din_q  <= '0;
      waw_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_din_q  <= rf_din_d;
      waw_q     <= waw_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= bus.mem_rd;
      fifo_data_q[wptr_q] <= bus.mem_data;
    end
  end

  assign bus.mem_ready  = mem_ready_w;
  assign bus.hazard     = busy_q[bus.rs1_addr] | busy_q[bus.rs2_addr];
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd_addr = rf_addr_q;
  assign bus.rf_rd_din  = rf_din_q;
  assign bus.waw_err    = waw_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
//------------------------------------------------------------------------------
// tb_regfile_writeback : directed self-checking bench for regfile_writeback
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_writeback;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  regfile_writeback_if bus ();

  regfile_writeback #(.FIFO_DEPTH(2)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle so registered outputs are visible.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
    if (we) begin
      chk({tag, ".addr"}, 32'(bus.rf_rd_addr), 32'(a));
      chk({tag, ".din"}, bus.rf_rd_din, d);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.issue_load = 1'b0; bus.issue_rd = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    #12;
    chk("rst.we",    32'(bus.rf_we), 32'd0);
    chk("rst.addr",  32'(bus.rf_rd_addr), 32'd0);
    chk("rst.din",   bus.rf_rd_din, 32'd0);
    chk("rst.waw",   32'(bus.waw_err), 32'd0);
    chk("rst.ready", 32'(bus.mem_ready), 32'd1);
    chk("rst.haz",   32'(bus.hazard), 32'd0);
    rstn = 1'b1;
    tick();
    wb("post_rst", 1'b0, 5'd0, 32'd0);

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234_5678;
    tick();
    wb("alu5", 1'b1, 5'd5, 32'h1234_5678);
    bus.alu_valid = 1'b0;
    tick();
    wb("alu5.idle", 1'b0, 5'd0, 32'd0);
    chk("alu5.hold", 32'(bus.rf_rd_addr), 32'd5);

    // Load to r7 with hazard tracking
    bus.issue_load = 1'b1; bus.issue_rd = 5'd7; bus.rs1_addr = 5'd7;
    #1;
    chk("haz.pre", 32'(bus.hazard), 32'd0);
    tick();
    bus.issue_load = 1'b0;
    chk("haz.set", 32'(bus.hazard), 32'd1);
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hCAFE_F00D;
    tick();
    bus.mem_valid = 1'b0;
    wb("ld7.nobypass", 1'b0, 5'd0, 32'd0);
    chk("ld7.haz_hold", 32'(bus.hazard), 32'd1);
    tick();
    wb("ld7", 1'b1, 5'd7, 32'hCAFE_F00D);
    chk("ld7.haz_clr", 32'(bus.hazard), 32'd0);
    bus.rs1_addr = 5'd0;

    // ALU priority for 4 cycles while loads to r3, r4 (and a third) are offered
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA10;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'hA3;
    tick();
    wb("pri.alu10", 1'b1, 5'd10, 32'hA10);
    chk("pri.ready1", 32'(bus.mem_ready), 32'd1);
    bus.alu_rd = 5'd11; bus.alu_data = 32'hA11;
    bus.mem_rd = 5'd4; bus.mem_data = 32'hA4;
    tick();
    wb("pri.alu11", 1'b1, 5'd11, 32'hA11);
    chk("pri.full", 32'(bus.mem_ready), 32'd0);
    bus.alu_rd = 5'd12; bus.alu_data = 32'hA12;
    bus.mem_rd = 5'd5; bus.mem_data = 32'hA5;
    tick();
    wb("pri.alu12", 1'b1, 5'd12, 32'hA12);
    chk("pri.full2", 32'(bus.mem_ready), 32'd0);
    bus.alu_rd = 5'd13; bus.alu_data = 32'hA13;
    tick();
    wb("pri.alu13", 1'b1, 5'd13, 32'hA13);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    tick();
    wb("pri.ld3", 1'b1, 5'd3, 32'hA3);
    chk("pri.ready_back", 32'(bus.mem_ready), 32'd1);
    tick();
    wb("pri.ld4", 1'b1, 5'd4, 32'hA4);
    tick();
    wb("pri.empty", 1'b0, 5'd0, 32'd0);

    // Writes to r0 discarded, FIFO still drains
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hBEEF;
    tick();
    wb("r0.alu_a", 1'b0, 5'd0, 32'd0);
    tick();
    wb("r0.alu_b", 1'b0, 5'd0, 32'd0);
    chk("r0.full", 32'(bus.mem_ready), 32'd0);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    tick();
    wb("r0.pop_a", 1'b0, 5'd0, 32'd0);
    chk("r0.ready", 32'(bus.mem_ready), 32'd1);
    tick();
    wb("r0.pop_b", 1'b0, 5'd0, 32'd0);
    tick();
    wb("r0.drained", 1'b0, 5'd0, 32'd0);
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h55;
    tick();
    bus.mem_valid = 1'b0;
    wb("r0.fresh_push", 1'b0, 5'd0, 32'd0);
    tick();
    wb("r0.fresh_pop", 1'b1, 5'd2, 32'h55);

    // WAW on a pending load, then reset with two buffered entries
    bus.issue_load = 1'b1; bus.issue_rd = 5'd9; bus.rs1_addr = 5'd9;
    tick();
    bus.issue_load = 1'b0;
    chk("waw.pre", 32'(bus.waw_err), 32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    tick();
    wb("waw.alu9", 1'b1, 5'd9, 32'h99);
    chk("waw.set", 32'(bus.waw_err), 32'd1);
    chk("waw.busy_kept", 32'(bus.hazard), 32'd1);
    bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd21; bus.mem_data = 32'h21;
    tick();
    chk("waw.sticky", 32'(bus.waw_err), 32'd1);
    tick();
    chk("rst2.full", 32'(bus.mem_ready), 32'd0);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst2.we",    32'(bus.rf_we), 32'd0);
    chk("rst2.addr",  32'(bus.rf_rd_addr), 32'd0);
    chk("rst2.din",   bus.rf_rd_din, 32'd0);
    chk("rst2.waw",   32'(bus.waw_err), 32'd0);
    chk("rst2.ready", 32'(bus.mem_ready), 32'd1);
    chk("rst2.haz",   32'(bus.hazard), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    wb("rst2.nowrite", 1'b0, 5'd0, 32'd0);
    tick();
    wb("rst2.discarded", 1'b0, 5'd0, 32'd0);
    chk("rst2.ready_after", 32'(bus.mem_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
